// File: rtl/serial_mag_comp_if.sv
// Operand, result and slice-handshake bundle for the serial magnitude comparator.
// The slave side is the sequencer; the master side is whoever issues compares and hosts the slice.
interface serial_mag_comp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             x;
    logic             y;
    logic             z;
    logic             err;
    logic             bit_a;
    logic             bit_b;
    logic             slice_gt;
    logic             slice_lt;
    logic             slice_eq;

    modport slave (
        input  start, a, b, slice_gt, slice_lt, slice_eq,
        output busy, done, x, y, z, err, bit_a, bit_b
    );

    modport master (
        output start, a, b, slice_gt, slice_lt, slice_eq,
        input  busy, done, x, y, z, err, bit_a, bit_b
    );
endinterface

// File: rtl/serial_mag_comp_ctrl.sv
// Walks two latched WIDTH-bit operands MSB-first through one shared 1-bit comparator slice
// and reports gt/lt/eq as x/y/z, with err flagging a slice that answered with a non-one-hot code.
module serial_mag_comp_ctrl #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_mag_comp_if.slave cmp
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_MAX  = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic slice_code_ok(input logic gt, input logic lt, input logic eq);
        return (gt & ~lt & ~eq) | (~gt & lt & ~eq) | (~gt & ~lt & eq);
    endfunction

    logic [1:0]       r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic             r_fgt;
    logic             r_flt;
    logic             r_busy;
    logic             r_done;
    logic             r_x;
    logic             r_y;
    logic             r_z;
    logic             r_err;
    logic             r_bit_a;
    logic             r_bit_b;

    logic [1:0]       w_state_nx;
    logic [IW-1:0]    w_idx_nx;
    logic [WIDTH-1:0] w_ra_nx;
    logic [WIDTH-1:0] w_rb_nx;
    logic             w_fgt_nx;
    logic             w_flt_nx;
    logic             w_busy_nx;
    logic             w_done_nx;
    logic             w_x_nx;
    logic             w_y_nx;
    logic             w_z_nx;
    logic             w_err_nx;
    logic             w_bit_a_nx;
    logic             w_bit_b_nx;

    logic             w_ok;
    logic             w_vgt;
    logic             w_vlt;

    // The first recorded mismatch wins; the current bit only decides when nothing was recorded yet.
    assign w_ok  = slice_code_ok(cmp.slice_gt, cmp.slice_lt, cmp.slice_eq);
    assign w_vgt = r_fgt | (~r_flt & cmp.slice_gt);
    assign w_vlt = r_flt | (~r_fgt & cmp.slice_lt);

    // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_ra_nx    = r_ra;
        w_rb_nx    = r_rb;
        w_fgt_nx   = r_fgt;
        w_flt_nx   = r_flt;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_z_nx     = r_z;
        w_err_nx   = r_err;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_bit_a_nx = 1'b0;
        w_bit_b_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmp.start) begin
                    w_ra_nx    = cmp.a;
                    w_rb_nx    = cmp.b;
                    w_idx_nx   = IDX_MAX;
                    w_fgt_nx   = 1'b0;
                    w_flt_nx   = 1'b0;
                    w_err_nx   = 1'b0;
                    w_busy_nx  = 1'b1;
                    w_bit_a_nx = cmp.a[WIDTH-1];
                    w_bit_b_nx = cmp.b[WIDTH-1];
                    w_state_nx = S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (!w_ok) begin
                    w_err_nx   = 1'b1;
                    w_x_nx     = 1'b0;
                    w_y_nx     = 1'b0;
                    w_z_nx     = 1'b0;
                    w_done_nx  = 1'b1;
                    w_state_nx = S_DONE;
                end else if ((EARLY_EXIT == 1'b1) && !cmp.slice_eq) begin
                    w_x_nx     = cmp.slice_gt;
                    w_y_nx     = cmp.slice_lt;
                    w_z_nx     = 1'b0;
                    w_done_nx  = 1'b1;
                    w_state_nx = S_DONE;
                end else if (r_idx == IDX_ZERO) begin
                    w_x_nx     = w_vgt;
                    w_y_nx     = w_vlt;
                    w_z_nx     = ~(w_vgt | w_vlt);
                    w_done_nx  = 1'b1;
                    w_state_nx = S_DONE;
                end else begin
                    if (!cmp.slice_eq && !r_fgt && !r_flt) begin
                        w_fgt_nx = cmp.slice_gt;
                        w_flt_nx = cmp.slice_lt;
                    end else begin
                        w_fgt_nx = r_fgt;
                        w_flt_nx = r_flt;
                    end
                    w_idx_nx   = r_idx - IDX_ONE;
                    w_busy_nx  = 1'b1;
                    w_bit_a_nx = r_ra[r_idx - IDX_ONE];
                    w_bit_b_nx = r_rb[r_idx - IDX_ONE];
                    w_state_nx = S_RUN;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any compare in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= IDX_MAX;
            r_ra    <= {WIDTH{1'b0}};
            r_rb    <= {WIDTH{1'b0}};
            r_fgt   <= 1'b0;
            r_flt   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_z     <= 1'b0;
            r_err   <= 1'b0;
            r_bit_a <= 1'b0;
            r_bit_b <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_ra    <= w_ra_nx;
            r_rb    <= w_rb_nx;
            r_fgt   <= w_fgt_nx;
            r_flt   <= w_flt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_z     <= w_z_nx;
            r_err   <= w_err_nx;
            r_bit_a <= w_bit_a_nx;
            r_bit_b <= w_bit_b_nx;
        end
    end

    assign cmp.busy  = r_busy;
    assign cmp.done  = r_done;
    assign cmp.x     = r_x;
    assign cmp.y     = r_y;
    assign cmp.z     = r_z;
    assign cmp.err   = r_err;
    assign cmp.bit_a = r_bit_a;
    assign cmp.bit_b = r_bit_b;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Scoreboard bench: one early-exit and one constant-latency comparator, each with a reference slice.
module tb_serial_mag_comp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tb_a;
    logic [7:0] tb_b;
    logic       start_e;
    logic       start_c;
    logic       bad;
    logic       cur;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;

    typedef struct {
        logic x;
        logic y;
        logic z;
        logic err;
        int   cyc;
    } exp_t;

    exp_t q_e[$];
    exp_t q_c[$];
    exp_t me;
    exp_t mc;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_mag_comp_if #(.WIDTH(8)) if_e ();
    serial_mag_comp_if #(.WIDTH(8)) if_c ();

    assign if_e.start    = start_e;
    assign if_e.a        = tb_a;
    assign if_e.b        = tb_b;
    assign if_e.slice_gt = bad | (if_e.bit_a & ~if_e.bit_b);
    assign if_e.slice_lt = bad | (~if_e.bit_a & if_e.bit_b);
    assign if_e.slice_eq = ~bad & ~(if_e.bit_a ^ if_e.bit_b);

    assign if_c.start    = start_c;
    assign if_c.a        = tb_a;
    assign if_c.b        = tb_b;
    assign if_c.slice_gt = bad | (if_c.bit_a & ~if_c.bit_b);
    assign if_c.slice_lt = bad | (~if_c.bit_a & if_c.bit_b);
    assign if_c.slice_eq = ~bad & ~(if_c.bit_a ^ if_c.bit_b);

    serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut_e (.clk(clk), .rst_n(rst_n), .cmp(if_e));
    serial_mag_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_c (.clk(clk), .rst_n(rst_n), .cmp(if_c));

    logic m_busy, m_done, m_err, m_bit_a, m_bit_b;
    assign m_busy  = cur ? if_c.busy  : if_e.busy;
    assign m_done  = cur ? if_c.done  : if_e.done;
    assign m_err   = cur ? if_c.err   : if_e.err;
    assign m_bit_a = cur ? if_c.bit_a : if_e.bit_a;
    assign m_bit_b = cur ? if_c.bit_b : if_e.bit_b;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain integer compare; latency from the highest differing bit.
    function automatic exp_t model(input bit early, input logic [7:0] av, input logic [7:0] bv,
                                   input bit bad_i, input int s);
        exp_t r;
        logic [7:0] d;
        int lat;
        int hi;
        if (bad_i) begin
            r.x = 1'b0; r.y = 1'b0; r.z = 1'b0; r.err = 1'b1; r.cyc = s + 1;
            return r;
        end
        r.x = (av > bv); r.y = (av < bv); r.z = (av == bv); r.err = 1'b0;
        d = av ^ bv;
        hi = -1;
        for (int i = 0; i < 8; i++) if (d[i]) hi = i;
        lat = (early && hi >= 0) ? (8 - hi) : 8;
        r.cyc = s + lat;
        return r;
    endfunction

    // Monitor: pops the expectation for whichever comparator signals done.
    always @(negedge clk) begin
        if (rst_n && if_e.done) begin
            chk("queue E", int'(q_e.size() > 0), 1);
            if (q_e.size() > 0) begin
                me = q_e.pop_front();
                chk("x E", int'(if_e.x), int'(me.x));
                chk("y E", int'(if_e.y), int'(me.y));
                chk("z E", int'(if_e.z), int'(me.z));
                chk("err E", int'(if_e.err), int'(me.err));
                chk("done cycle E", cyc, me.cyc);
            end
        end
        if (rst_n && if_c.done) begin
            chk("queue C", int'(q_c.size() > 0), 1);
            if (q_c.size() > 0) begin
                mc = q_c.pop_front();
                chk("x C", int'(if_c.x), int'(mc.x));
                chk("y C", int'(if_c.y), int'(mc.y));
                chk("z C", int'(if_c.z), int'(mc.z));
                chk("err C", int'(if_c.err), int'(mc.err));
                chk("done cycle C", cyc, mc.cyc);
            end
        end
    end

    task automatic do_cmp(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                          input bit bad_i, input bit repulse);
        exp_t e;
        int   s;
        int   busy_n;
        int   k;
        busy_n = 0;
        k = 0;
        @(negedge clk);
        cur = sel; tb_a = av; tb_b = bv; bad = bad_i;
        if (sel) start_c = 1'b1; else start_e = 1'b1;
        s = cyc + 1;
        e = model(!sel, av, bv, bad_i, s);
        if (sel) q_c.push_back(e); else q_e.push_back(e);
        @(negedge clk);
        start_e = 1'b0; start_c = 1'b0;
        tb_a = 8'($urandom); tb_b = 8'($urandom);
        chk("err cleared on start", int'(m_err), 0);
        while (!m_done && k < 20) begin
            if (m_busy) begin
                if (busy_n < 8) begin
                    chk("bit_a", int'(m_bit_a), int'(av[7 - busy_n]));
                    chk("bit_b", int'(m_bit_b), int'(bv[7 - busy_n]));
                end
                busy_n++;
            end
            if (repulse && k == 2) begin
                if (sel) start_c = 1'b1; else start_e = 1'b1;
                tb_a = 8'h00; tb_b = 8'h00;
            end else begin
                start_e = 1'b0; start_c = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start_e = 1'b0; start_c = 1'b0;
        chk("done seen", int'(m_done), 1);
        chk("busy at done", int'(m_busy), 0);
        chk("busy cycles", busy_n, e.cyc - s);
        @(negedge clk);
        bad = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] one;
        exp_t e;
        int   s;
        start_e = 1'b0; start_c = 1'b0; bad = 1'b0; cur = 1'b0; tb_a = 8'h00; tb_b = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset outputs E", int'({if_e.busy, if_e.done, if_e.x, if_e.y, if_e.z, if_e.err,
                                     if_e.bit_a, if_e.bit_b}), 0);
        chk("reset outputs C", int'({if_c.busy, if_c.done, if_c.x, if_c.y, if_c.z, if_c.err,
                                     if_c.bit_a, if_c.bit_b}), 0);
        rst_n = 1'b1;

        do_cmp(1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0);
        do_cmp(1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0);
        do_cmp(1'b0, 8'h80, 8'h7F, 1'b0, 1'b0);
        do_cmp(1'b1, 8'h40, 8'h00, 1'b0, 1'b0);
        do_cmp(1'b1, 8'h4F, 8'h30, 1'b0, 1'b0);
        do_cmp(1'b1, 8'h12, 8'h13, 1'b0, 1'b1);
        do_cmp(1'b0, 8'h12, 8'h13, 1'b0, 1'b1);

        // Reset in the middle of a constant-latency run; nothing is expected from it.
        @(negedge clk);
        cur = 1'b1; tb_a = 8'hF0; tb_b = 8'h0F; start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-run reset C", int'({if_c.busy, if_c.done, if_c.x, if_c.y, if_c.z, if_c.err,
                                     if_c.bit_a, if_c.bit_b}), 0);
        chk("mid-run reset E", int'({if_e.busy, if_e.done, if_e.x, if_e.y, if_e.z, if_e.err,
                                     if_e.bit_a, if_e.bit_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_cmp(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);

        do_cmp(1'b0, 8'h37, 8'h37, 1'b1, 1'b0);
        do_cmp(1'b0, 8'h05, 8'h03, 1'b0, 1'b0);
        do_cmp(1'b1, 8'h9C, 8'h11, 1'b1, 1'b0);
        do_cmp(1'b1, 8'h22, 8'h22, 1'b0, 1'b0);

        // Start held high: the second launch lands on the first IDLE edge after DONE.
        @(negedge clk);
        cur = 1'b0; tb_a = 8'h80; tb_b = 8'h7F; start_e = 1'b1;
        s = cyc + 1;
        e = model(1'b1, 8'h80, 8'h7F, 1'b0, s);
        q_e.push_back(e);
        e = model(1'b1, 8'h80, 8'h7F, 1'b0, s + 3);
        q_e.push_back(e);
        repeat (4) @(negedge clk);
        start_e = 1'b0;
        repeat (3) @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: begin
                    one = 8'h01;
                    rb = ra ^ (one << $urandom_range(0, 7));
                end
                default: rb = 8'($urandom);
            endcase
            do_cmp(1'($urandom_range(0, 1)), ra, rb, 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard drained", q_e.size() + q_c.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
